// File: rtl/audio_pkg.sv
// Shared audio-path types: default word width, I2S receiver states and the
// sample word type used across the capture/playback chain.
package audio_pkg;

    localparam int unsigned DEFAULT_SAMPLE_WIDTH = 16;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } i2s_rx_state_t;

    typedef logic [DEFAULT_SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S capture: oversampled SCK/WS/SD, delivers left/right word pairs
// with a one-cycle valid strobe and a sticky framing-error flag.
module i2s_receiver
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH   = DEFAULT_SAMPLE_WIDTH,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    input_clk,
    input  logic                    reset,
    input  logic                    i2s_serial_clk,
    input  logic                    i2s_ws,
    input  logic                    i2s_sound_bit_in,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    sample_valid,
    output logic                    frame_error
);

    localparam int unsigned CNT_W  = $clog2(SAMPLE_WIDTH + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic sck_s, ws_s, sd_s, sck_d, sck_rise;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(input_clk), .reset(reset), .d(i2s_serial_clk), .q(sck_s));
    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_ws (
        .clk(input_clk), .reset(reset), .d(i2s_ws), .q(ws_s));
    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_sd (
        .clk(input_clk), .reset(reset), .d(i2s_sound_bit_in), .q(sd_s));

    assign sck_rise = sck_s & ~sck_d;

    i2s_rx_state_t           state, state_nx;
    logic [SAMPLE_WIDTH-1:0] shift_reg, shift_reg_nx;
    logic [CNT_W-1:0]        bit_count, bit_count_nx;
    logic                    ws_prev, ws_prev_nx;
    logic [IDLE_W-1:0]       idle_cnt, idle_cnt_nx;
    logic                    left_seen, left_seen_nx;
    logic [SAMPLE_WIDTH-1:0] left_nx, right_nx;
    logic                    valid_nx, error_nx;
    logic [SAMPLE_WIDTH-1:0] shifted, word;
    logic [CNT_W-1:0]        count_inc;

    always_ff @(posedge input_clk or negedge reset) begin
        if (!reset) begin
            sck_d        <= 1'b0;
            state        <= SYNC;
            shift_reg    <= '0;
            bit_count    <= '0;
            ws_prev      <= 1'b0;
            idle_cnt     <= '0;
            left_seen    <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            sck_d        <= sck_s;
            state        <= state_nx;
            shift_reg    <= shift_reg_nx;
            bit_count    <= bit_count_nx;
            ws_prev      <= ws_prev_nx;
            idle_cnt     <= idle_cnt_nx;
            left_seen    <= left_seen_nx;
            left_sample  <= left_nx;
            right_sample <= right_nx;
            sample_valid <= valid_nx;
            frame_error  <= error_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        shift_reg_nx = shift_reg;
        bit_count_nx = bit_count;
        ws_prev_nx   = ws_prev;
        left_seen_nx = left_seen;
        left_nx      = left_sample;
        right_nx     = right_sample;
        valid_nx     = 1'b0;
        error_nx     = frame_error;
        shifted      = shift_reg;
        count_inc    = bit_count;
        word         = '0;

        if (sck_rise) begin
            idle_cnt_nx = '0;
        end else if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES)) begin
            idle_cnt_nx = idle_cnt + 1'b1;
        end else begin
            idle_cnt_nx = idle_cnt;
        end

        case (state)
            SYNC: begin
                if (sck_rise && (ws_s != ws_prev)) begin
                    state_nx     = RUN;
                    bit_count_nx = '0;
                    ws_prev_nx   = ws_s;
                    left_seen_nx = 1'b0;
                end
            end
            RUN: begin
                if (sck_rise) begin
                    if (bit_count < CNT_W'(SAMPLE_WIDTH)) begin
                        shifted   = {shift_reg[SAMPLE_WIDTH-2:0], sd_s};
                        count_inc = bit_count + 1'b1;
                    end
                    shift_reg_nx = shifted;
                    bit_count_nx = count_inc;
                    // WS edge: this rise carried the closing word's LSB
                    if (ws_s != ws_prev) begin
                        word = shifted;
                        if (count_inc < CNT_W'(SAMPLE_WIDTH)) begin
                            word     = shifted << (CNT_W'(SAMPLE_WIDTH) - count_inc);
                            error_nx = 1'b1;
                        end
                        if (!ws_prev) begin
                            left_nx      = word;
                            left_seen_nx = 1'b1;
                        end else if (left_seen) begin
                            // right word without a preceding left is the post-sync fragment
                            right_nx = word;
                            valid_nx = 1'b1;
                        end
                        bit_count_nx = '0;
                        ws_prev_nx   = ws_s;
                    end
                end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES)) begin
                    state_nx     = SYNC;
                    error_nx     = 1'b1;
                    bit_count_nx = '0;
                    shift_reg_nx = '0;
                end
            end
            default: state_nx = SYNC;
        endcase
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: Philips-format stream generator with
// hand-computed expected words, pulse capture and sticky-error checks.
module tb_i2s_receiver;
    import audio_pkg::*;

    logic        input_clk = 1'b0;
    logic        reset;
    logic        i2s_serial_clk;
    logic        i2s_ws;
    logic        i2s_sound_bit_in;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        sample_valid;
    logic        frame_error;

    int vec_count = 0;
    int err_count = 0;

    int          pulse_cnt = 0;
    int          dbl_cnt   = 0;
    logic        valid_q   = 1'b0;
    logic [15:0] cap_l [0:63];
    logic [15:0] cap_r [0:63];
    logic        pending   = 1'b0;
    int          base;

    i2s_receiver #(
        .SAMPLE_WIDTH  (16),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .input_clk       (input_clk),
        .reset           (reset),
        .i2s_serial_clk  (i2s_serial_clk),
        .i2s_ws          (i2s_ws),
        .i2s_sound_bit_in(i2s_sound_bit_in),
        .left_sample     (left_sample),
        .right_sample    (right_sample),
        .sample_valid    (sample_valid),
        .frame_error     (frame_error)
    );

    always #5 input_clk = ~input_clk;

    always @(negedge input_clk) begin
        if (sample_valid) begin
            if (pulse_cnt < 64) begin
                cap_l[pulse_cnt] = left_sample;
                cap_r[pulse_cnt] = right_sample;
            end
            pulse_cnt = pulse_cnt + 1;
            if (valid_q) dbl_cnt = dbl_cnt + 1;
        end
        valid_q = sample_valid;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One SCK period: data/WS change with the falling edge, sampled on the rise.
    task automatic send_period(input logic w, input logic d);
        i2s_ws           = w;
        i2s_sound_bit_in = d;
        i2s_serial_clk   = 1'b0;
        repeat (4) @(negedge input_clk);
        i2s_serial_clk = 1'b1;
        repeat (4) @(negedge input_clk);
    endtask

    // Slot of n periods; first period carries the previous word's LSB.
    task automatic send_slot(input logic w, input logic [31:0] word, input int n, input int periods);
        for (int p = 0; p < periods; p++) begin
            if (p == 0) send_period(w, pending);
            else        send_period(w, word[n-p]);
        end
        if (periods == n) pending = word[0];
    endtask

    task automatic check_pair(input string tag, input int idx, input logic [15:0] l, input logic [15:0] r);
        check_value({tag, "_left"},  32'(cap_l[idx]), 32'(l));
        check_value({tag, "_right"}, 32'(cap_r[idx]), 32'(r));
    endtask

    initial begin
        reset            = 1'b0;
        i2s_serial_clk   = 1'b0;
        i2s_ws           = 1'b0;
        i2s_sound_bit_in = 1'b0;
        repeat (4) @(negedge input_clk);
        check_value("rst_left",  32'(left_sample),  32'h0);
        check_value("rst_right", 32'(right_sample), 32'h0);
        check_value("rst_valid", 32'(sample_valid), 32'h0);
        check_value("rst_error", 32'(frame_error),  32'h0);
        reset = 1'b1;
        repeat (2) @(negedge input_clk);

        // 16-bit slots after one sync frame
        send_slot(1'b0, 32'h0000, 16, 16);
        send_slot(1'b1, 32'h0000, 16, 16);
        send_slot(1'b0, 32'hA5C3, 16, 16);
        check_value("sync_no_pulse", 32'(pulse_cnt), 32'd0);
        send_slot(1'b1, 32'h1234, 16, 16);
        base = pulse_cnt;
        send_slot(1'b0, 32'h0001, 16, 16);
        check_value("basic_pulses", 32'(pulse_cnt - base), 32'd1);
        check_pair("basic", base, 16'hA5C3, 16'h1234);
        check_value("basic_error", 32'(frame_error), 32'h0);

        // back-to-back frames
        base = pulse_cnt;
        send_slot(1'b1, 32'hFFFF, 16, 16);
        send_slot(1'b0, 32'h7FFF, 16, 16);
        send_slot(1'b1, 32'h8000, 16, 16);
        send_slot(1'b0, 32'h0000, 16, 16);
        check_value("b2b_pulses", 32'(pulse_cnt - base), 32'd2);
        check_pair("b2b_first", base, 16'h0001, 16'hFFFF);
        check_pair("b2b_second", base + 1, 16'h7FFF, 16'h8000);

        // 32-bit slots, trailing bits discarded
        base = pulse_cnt;
        send_slot(1'b1, 32'h0000, 16, 16);
        send_slot(1'b0, 32'h8001_FFFF, 32, 32);
        send_slot(1'b1, 32'h7FFE_0000, 32, 32);
        send_slot(1'b0, 32'h1357, 16, 16);
        check_value("w32_pulses", 32'(pulse_cnt - base), 32'd2);
        check_pair("w32_zero", base, 16'h0000, 16'h0000);
        check_pair("w32", base + 1, 16'h8001, 16'h7FFE);
        check_value("w32_error", 32'(frame_error), 32'h0);

        // SCK stall mid-word
        base = pulse_cnt;
        send_slot(1'b1, 32'h2468, 16, 16);
        send_slot(1'b0, 32'h9999, 16, 8);
        i2s_serial_clk = 1'b0;
        repeat (1100) @(negedge input_clk);
        check_value("to_pulses", 32'(pulse_cnt - base), 32'd1);
        check_pair("to_last", base, 16'h1357, 16'h2468);
        check_value("to_error", 32'(frame_error), 32'h1);
        check_value("to_state", 32'(dut.state), 32'(SYNC));
        check_value("to_hold_left",  32'(left_sample),  32'h1357);
        check_value("to_hold_right", 32'(right_sample), 32'h2468);
        base = pulse_cnt;
        send_slot(1'b1, 32'h0000, 16, 16);
        send_slot(1'b0, 32'h4444, 16, 16);
        check_value("resync_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check_value("resync_hold_left",  32'(left_sample),  32'h1357);
        check_value("resync_hold_right", 32'(right_sample), 32'h2468);
        send_slot(1'b1, 32'h5555, 16, 16);
        send_slot(1'b0, 32'h6666, 16, 16);
        check_value("resync_pulses", 32'(pulse_cnt - base), 32'd1);
        check_pair("resync", base, 16'h4444, 16'h5555);

        // reset mid right word
        send_slot(1'b1, 32'h7777, 16, 8);
        reset = 1'b0;
        #1;
        check_value("mid_rst_left",  32'(left_sample),  32'h0);
        check_value("mid_rst_right", 32'(right_sample), 32'h0);
        check_value("mid_rst_valid", 32'(sample_valid), 32'h0);
        check_value("mid_rst_error", 32'(frame_error),  32'h0);
        check_value("mid_rst_state", 32'(dut.state),    32'(SYNC));
        i2s_serial_clk = 1'b0;
        repeat (4) @(negedge input_clk);
        reset = 1'b1;
        repeat (2) @(negedge input_clk);
        base = pulse_cnt;
        send_slot(1'b0, 32'h0F0F, 16, 16);
        send_slot(1'b1, 32'hF0F0, 16, 16);
        send_slot(1'b0, 32'h3C3C, 16, 16);
        send_slot(1'b1, 32'hC3C3, 16, 16);
        send_slot(1'b0, 32'h1111, 16, 16);
        check_value("post_rst_pulses", 32'(pulse_cnt - base), 32'd1);
        check_pair("post_rst", base, 16'h3C3C, 16'hC3C3);
        check_value("post_rst_error", 32'(frame_error), 32'h0);

        // short 12-bit left slot, sticky error
        base = pulse_cnt;
        send_slot(1'b1, 32'h2222, 16, 16);
        send_slot(1'b0, 32'h0ABC, 12, 12);
        send_slot(1'b1, 32'h3333, 16, 16);
        check_value("short_left",  32'(left_sample), 32'hABC0);
        check_value("short_error", 32'(frame_error), 32'h1);
        send_slot(1'b0, 32'h4444, 16, 16);
        send_slot(1'b1, 32'h5555, 16, 16);
        send_slot(1'b0, 32'h6666, 16, 16);
        check_value("short_pulses", 32'(pulse_cnt - base), 32'd3);
        check_pair("short_pair0", base, 16'h1111, 16'h2222);
        check_pair("short_pair1", base + 1, 16'hABC0, 16'h3333);
        check_pair("short_pair2", base + 2, 16'h4444, 16'h5555);
        check_value("sticky_error", 32'(frame_error), 32'h1);

        check_value("valid_width", 32'(dbl_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
